// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and
// the slice width used by the datapath.
package nibble_serial_adder_pkg;

  // Slice width: one nibble is added per RUN cycle.
  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : nibble_serial_adder_pkg

// File: rtl/carry_skip_adder_4bit.sv
// 4-bit carry-skip adder slice. It ripples the carry through the slice.
// When every bit propagates, the carry input bypasses the ripple chain.
module carry_skip_adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a_i,
  input  logic [NIBBLE-1:0] b_i,
  input  logic              c_i,
  output logic [NIBBLE-1:0] s_o,
  output logic              c_o
);

  logic [NIBBLE-1:0] p;
  logic [NIBBLE-1:0] g;
  logic              c1;
  logic              c2;
  logic              c3;
  logic              c4;

  assign p  = a_i ^ b_i;
  assign g  = a_i & b_i;

  // Ripple chain, one named carry per bit position.
  assign c1 = g[0] | (p[0] & c_i);
  assign c2 = g[1] | (p[1] & c1);
  assign c3 = g[2] | (p[2] & c2);
  assign c4 = g[3] | (p[3] & c3);

  assign s_o = p ^ {c3, c2, c1, c_i};

  // Skip path: a fully propagating slice passes the carry input straight out.
  assign c_o = (&p) ? c_i : c4;

endmodule : carry_skip_adder_4bit

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder. It accepts two WIDTH-bit operands and a carry-in.
// It adds one nibble per cycle through a single 4-bit slice.
// It then holds the result until the downstream handshake completes.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature: define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to add a registered
// signed-overflow output.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NUM_NIBBLES = WIDTH / NIBBLE;
  localparam int CNT_W       = $clog2(NUM_NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NUM_NIBBLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [WIDTH-1:0]  left_q;
  logic [WIDTH-1:0]  right_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  logic              accept;
  logic [NIBBLE-1:0] slice_a;
  logic [NIBBLE-1:0] slice_b;
  logic [NIBBLE-1:0] slice_sum;
  logic              slice_cout;

  // The captured operands feed the slice one nibble at a time.
  assign slice_a = left_q[cnt_q*NIBBLE +: NIBBLE];
  assign slice_b = right_q[cnt_q*NIBBLE +: NIBBLE];

  carry_skip_adder_4bit u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_sum),
    .c_o (slice_cout)
  );

  // Next-state, datapath-update and handshake logic for the three-state FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    accept    = (state_q == IDLE) && in_valid;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = carry_in;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        sum_d[cnt_q*NIBBLE +: NIBBLE] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_NIBBLE) begin
          state_d = DONE;
          cout_d  = slice_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
          // The top nibble of the slice sum holds the result MSB.
          ovf_d   = (left_q[WIDTH-1] == right_q[WIDTH-1]) &&
                    (slice_sum[NIBBLE-1] != left_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // All registers then update together at the edge, with no order dependence.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand capture on accept. Inputs are ignored at all other times.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers have no reset. They are only read in RUN,
    // and an accept always loads them before RUN is entered.
    if (accept && !reset) begin
      left_q  <= left;
      right_q <= right;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16. It uses directed
// vectors plus a long random run against a behavioural sum model.
// The overflow checks are present when NIBBLE_SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .left      (left),
    .right     (right),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge. The DUT is sampled and driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands in IDLE, then scramble the inputs after the accept edge.
  // Wait (bounded) for out_valid and return the number of cycles it took.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output int lat);
    left     = a;
    right    = b;
    carry_in = cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    left     = W'($urandom);
    right    = W'($urandom);
    carry_in = ~cin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Complete the output handshake.
  task automatic end_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    left = '0; right = '0; carry_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (sum !== 16'h0000 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: sum=%h carry_out=%b, want 0000 0", sum, carry_out);
    end
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: overflow=%b, want 0", overflow);
    end
`endif
  endtask

  // 0x1234 + 0x4321 + 1: checks latency and the busy/in_ready window.
  task automatic test_latency();
    left = 16'h1234; right = 16'h4321; carry_in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== (i == 4)) begin
        errors++;
        $display("FAIL latency_cycle%0d: in_ready=%b busy=%b out_valid=%b, want 0 1 %b",
                 i, in_ready, busy, out_valid, (i == 4));
      end
      if (i < 4) tick();
    end
    checks++;
    if (sum !== 16'h5556 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL latency_result: sum=%h carry_out=%b, want 5556 0", sum, carry_out);
    end
    end_op();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        sum !== 16'h5556 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b, want 1 0 0 5556 0",
               in_ready, busy, out_valid, sum, carry_out);
    end
  endtask

  // Directed table, including the carry wrap and the signed-overflow corners.
  task automatic test_vectors();
    logic [W-1:0] va   [6] = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0F0F, 16'h7FFF, 16'hA5C3};
    logic [W-1:0] vb   [6] = '{16'h0001, 16'h8000, 16'h0000, 16'hF0F0, 16'h0001, 16'h3C5A};
    logic         vc   [6] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
    logic [W-1:0] es   [6] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 16'hE21D};
    logic         eco  [6] = '{1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
    logic         eov  [6] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== 4 || sum !== es[i] || carry_out !== eco[i]) begin
        errors++;
        $display("FAIL vec%0d: lat=%0d sum=%h cout=%b, want 4 %h %b",
                 i, lat, sum, carry_out, es[i], eco[i]);
      end
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      checks++;
      if (overflow !== eov[i]) begin
        errors++;
        $display("FAIL vec%0d_ovf: overflow=%b, want %b", i, overflow, eov[i]);
      end
`else
      if (eov[i] === 1'bx) $display("unreachable");
`endif
      end_op();
    end
  endtask

  // Stall in DONE with inputs toggling; result must hold.
  task automatic test_stall();
    int lat;
    start_op(16'hA5C3, 16'h3C5A, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      left = ~left; right = right ^ 16'h5A5A; carry_in = ~carry_in; in_valid = ~in_valid;
      tick();
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'hE21D || carry_out !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: out_valid=%b sum=%h cout=%b, want 1 e21d 0",
                 i, out_valid, sum, carry_out);
      end
    end
    in_valid = 1'b0;
    end_op();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  // Reset two cycles into RUN: operation discarded, no out_valid ever.
  task automatic test_mid_run_reset();
    logic seen_valid;
    left = 16'h1111; right = 16'h2222; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        sum !== 16'h0000 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b, want 1 0 0 0000 0",
               in_ready, busy, out_valid, sum, carry_out);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_valid: out_valid seen=%b, want 0", seen_valid);
    end
    // Reset wins over a simultaneous accept.
    in_valid = 1'b1; left = 16'hFFFF; right = 16'hFFFF; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  // Back-to-back random operations with random downstream stalls.
  task automatic test_random();
    logic [W-1:0] a, b;
    logic         cin;
    logic [W:0]   exp;
    int           lat, stall, bad;
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      start_op(a, b, cin, lat);
      for (int s = 0; s < stall; s++) tick();
      checks++;
      if (lat !== 4 || out_valid !== 1'b1 || sum !== exp[W-1:0] || carry_out !== exp[W]) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand%0d: %h+%h+%b lat=%0d sum=%h cout=%b, want 4 %h %b",
                   n, a, b, cin, lat, sum, carry_out, exp[W-1:0], exp[W]);
        bad++;
      end
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      checks++;
      if (overflow !== ((a[W-1] == b[W-1]) && (exp[W-1] != a[W-1]))) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand%0d_ovf: overflow=%b for %h+%h+%b", n, overflow, a, b, cin);
        bad++;
      end
`endif
      end_op();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_stall();
    test_mid_run_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nibble_serial_adder
